// File: rtl/uart_text_tx.sv
// Streams the non-zero bytes of a 32-byte text buffer (byte 31 first) as 8N1 UART frames,
// optionally followed by CR LF, then holds a completion flag until the request is withdrawn.
//
// state | meaning
// IDLE  | line high, waiting for write_uart
// SCAN  | examine one byte index (or newline slot) per cycle
// START | drive start bit (0)
// DATA  | drive 8 data bits, LSB first
// STOP  | drive stop bit (1)
// DONE  | message finished, uart_written high until write_uart falls
module uart_text_tx #(
  parameter int CLKS_PER_BIT   = 234,
  parameter int APPEND_NEWLINE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] uart_data,
  input  logic         write_uart,
  output logic         uart_written,
  output logic         uart_tx,
  output logic         busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SCAN, START, DATA, STOP, DONE} state_t;
  // Where the scan pointer sits: inside the buffer, at the CR slot, at the LF slot, or past the end.
  typedef enum logic [1:0] {TAIL_BUF, TAIL_CR, TAIL_LF, TAIL_END} tail_t;

  state_t          state, state_nxt;
  tail_t           tail, tail_nxt;
  logic [255:0]    shadow, shadow_nxt;
  logic [4:0]      byte_idx, byte_idx_nxt;
  logic [7:0]      shift_reg, shift_nxt;
  logic [TW-1:0]   bit_timer, bit_timer_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      cur_byte;
  logic            bit_tick;

  assign cur_byte = shadow[{byte_idx, 3'b000} +: 8];
  assign bit_tick = (bit_timer == TMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tail      <= TAIL_BUF;
      shadow    <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      bit_timer <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      tail      <= tail_nxt;
      shadow    <= shadow_nxt;
      byte_idx  <= byte_idx_nxt;
      shift_reg <= shift_nxt;
      bit_timer <= bit_timer_nxt;
      bit_cnt   <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tail_nxt      = tail;
    shadow_nxt    = shadow;
    byte_idx_nxt  = byte_idx;
    shift_nxt     = shift_reg;
    bit_timer_nxt = bit_timer;
    bit_cnt_nxt   = bit_cnt;
    uart_tx       = 1'b1;
    uart_written  = 1'b0;
    busy          = (state != IDLE);

    if (state == START || state == DATA || state == STOP)
      bit_timer_nxt = bit_tick ? '0 : bit_timer + 1'b1;

    case (state)
      IDLE: begin
        if (write_uart) begin
          shadow_nxt   = uart_data;
          byte_idx_nxt = 5'd31;
          tail_nxt     = TAIL_BUF;
          state_nxt    = SCAN;
        end
      end

      SCAN: begin
        bit_timer_nxt = '0;
        case (tail)
          TAIL_BUF: begin
            if (cur_byte != 8'h00) begin
              shift_nxt = cur_byte;
              state_nxt = START;
            end
            // The pointer advances as the byte is examined, so STOP knows where to resume.
            if (byte_idx == 5'd0) begin
              tail_nxt = (APPEND_NEWLINE != 0) ? TAIL_CR : TAIL_END;
              if (cur_byte == 8'h00 && APPEND_NEWLINE == 0)
                state_nxt = DONE;
            end else begin
              byte_idx_nxt = byte_idx - 5'd1;
            end
          end
          TAIL_CR: begin
            shift_nxt = 8'h0D;
            tail_nxt  = TAIL_LF;
            state_nxt = START;
          end
          TAIL_LF: begin
            shift_nxt = 8'h0A;
            tail_nxt  = TAIL_END;
            state_nxt = START;
          end
          default: state_nxt = DONE;
        endcase
      end

      START: begin
        uart_tx = 1'b0;
        if (bit_tick) begin
          bit_cnt_nxt = 3'd0;
          state_nxt   = DATA;
        end
      end

      DATA: begin
        uart_tx = shift_reg[0];
        if (bit_tick) begin
          shift_nxt   = {1'b0, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_nxt = STOP;
        end
      end

      STOP: begin
        if (bit_tick)
          state_nxt = (tail == TAIL_END) ? DONE : SCAN;
      end

      DONE: begin
        uart_written = 1'b1;
        if (!write_uart)
          state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_text_tx.sv
// Scoreboard bench for uart_text_tx: one instance with CR LF appended, one without.
// Expected bytes are queued by the stimulus; per-instance monitors decode frames and pop.
module tb_uart_text_tx;

  localparam int CPB = 4;
  localparam logic [79:0] MSG = "PRINT 0012";

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         reset_a, write_a, written_a, tx_a, busy_a;
  logic         reset_b, write_b, written_b, tx_b, busy_b;
  logic [255:0] data_a, data_b;

  uart_text_tx #(.CLKS_PER_BIT(CPB), .APPEND_NEWLINE(1)) dut_nl (
    .clk(clk), .reset(reset_a), .uart_data(data_a), .write_uart(write_a),
    .uart_written(written_a), .uart_tx(tx_a), .busy(busy_a));

  uart_text_tx #(.CLKS_PER_BIT(CPB), .APPEND_NEWLINE(0)) dut_raw (
    .clk(clk), .reset(reset_b), .uart_data(data_b), .write_uart(write_b),
    .uart_written(written_b), .uart_tx(tx_b), .busy(busy_b));

  logic tx_v [2];
  logic rst_v [2];
  logic written_v [2];
  logic busy_v [2];
  assign tx_v[0] = tx_a;           assign tx_v[1] = tx_b;
  assign rst_v[0] = reset_a;       assign rst_v[1] = reset_b;
  assign written_v[0] = written_a; assign written_v[1] = written_b;
  assign busy_v[0] = busy_a;       assign busy_v[1] = busy_b;

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int         st_b [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_msg(input int d);
    logic [79:0] m;
    m = MSG;
    for (int i = 9; i >= 0; i--) begin
      if (d == 0) exp_a.push_back(m[i*8 +: 8]);
      else        exp_b.push_back(m[i*8 +: 8]);
    end
    if (d == 0) begin
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
    end
  endtask

  task automatic monitor(input int d);
    logic       s [40];
    logic [7:0] got;
    logic [7:0] want;
    bit         aborted;
    bit         shape_ok;
    int         t0;
    forever begin
      @(negedge clk);
      if (!rst_v[d] && !tx_v[d]) begin
        t0 = cyc;
        s[0] = 1'b0;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst_v[d]) aborted = 1'b1;
          s[i] = tx_v[d];
          if (aborted) break;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < 4; k++)
              if (s[b*4+k] !== s[b*4]) shape_ok = 1'b0;
          for (int b = 0; b < 8; b++) got[b] = s[4 + 4*b];
          check(d == 0 ? "nl_bit_timing" : "raw_bit_timing", {31'd0, shape_ok}, 32'd1);
          check(d == 0 ? "nl_stop_bit" : "raw_stop_bit", {31'd0, s[36]}, 32'd1);
          if (d == 1) st_b.push_back(t0);
          if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame dut%0d: got %02h, expected no frame", d, got);
          end else begin
            want = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
            check(d == 0 ? "nl_frame_byte" : "raw_frame_byte", {24'd0, got}, {24'd0, want});
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_written(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (written_v[d]) ok = 1'b1;
    end
  endtask

  task automatic wait_tx_low(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!tx_v[d]) ok = 1'b1;
    end
  endtask

  task automatic finish_msg(input int d, input string tag);
    bit ok;
    wait_written(d, 3000, ok);
    check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
    check({tag, "_frames_left"}, (d == 0) ? exp_a.size() : exp_b.size(), 32'd0);
    tick();
    if (d == 0) write_a = 1'b0; else write_b = 1'b0;
    @(negedge clk);
    check({tag, "_written_held"}, {31'd0, written_v[d]}, 32'd1);
    tick();
    @(negedge clk);
    check({tag, "_written_clear"}, {31'd0, written_v[d]}, 32'd0);
    check({tag, "_busy_clear"}, {31'd0, busy_v[d]}, 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    reset_a = 1'b1; reset_b = 1'b1;
    write_a = 1'b0; write_b = 1'b0;
    data_a = '0;    data_b = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_nl", {31'd0, tx_a}, 32'd1);
    check("rst_busy_nl", {31'd0, busy_a}, 32'd0);
    check("rst_written_nl", {31'd0, written_a}, 32'd0);
    check("rst_tx_raw", {31'd0, tx_b}, 32'd1);
    check("rst_busy_raw", {31'd0, busy_b}, 32'd0);
    check("rst_written_raw", {31'd0, written_b}, 32'd0);
    tick();
    reset_a = 1'b0; reset_b = 1'b0;
    repeat (2) tick();

    // Full message with write_uart held throughout
    push_msg(0);
    data_a = {176'd0, MSG};
    write_a = 1'b1;
    finish_msg(0, "msg");

    // Buffer overwritten right after acceptance must not leak into the frames
    repeat (2) tick();
    push_msg(0);
    data_a = {176'd0, MSG};
    write_a = 1'b1;
    tick();
    data_a = {256{1'b1}};
    finish_msg(0, "shadow");

    // Reset during data bit 3 of the first frame, then a fresh request
    repeat (2) tick();
    data_a = {176'd0, MSG};
    write_a = 1'b1;
    wait_tx_low(0, 200, ok);
    check("rstmid_start_seen", {31'd0, ok}, 32'd1);
    repeat (17) @(negedge clk);
    tick();
    reset_a = 1'b1;
    write_a = 1'b0;
    tick();
    reset_a = 1'b0;
    @(negedge clk);
    check("rstmid_tx_high", {31'd0, tx_a}, 32'd1);
    check("rstmid_busy_low", {31'd0, busy_a}, 32'd0);
    repeat (2) tick();
    push_msg(0);
    write_a = 1'b1;
    finish_msg(0, "rstmid_retry");

    // All-zero buffer: only CR LF
    repeat (2) tick();
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
    data_a = '0;
    write_a = 1'b1;
    finish_msg(0, "zero_nl");

    // write_uart dropped mid-message: completes, completion flag lasts one cycle
    repeat (2) tick();
    push_msg(0);
    data_a = {176'd0, MSG};
    write_a = 1'b1;
    wait_tx_low(0, 200, ok);
    check("drop_start_seen", {31'd0, ok}, 32'd1);
    tick();
    write_a = 1'b0;
    wait_written(0, 3000, ok);
    check("drop_done_seen", {31'd0, ok}, 32'd1);
    check("drop_frames_left", exp_a.size(), 32'd0);
    n = ok ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (written_a) n++;
    end
    check("drop_written_pulse", n, 32'd1);
    check("drop_busy_clear", {31'd0, busy_a}, 32'd0);

    // Two 0x41 bytes at the buffer ends, no newline: 40-cycle frame + 31 scan cycles apart
    st_b.delete();
    data_b = '0;
    data_b[255:248] = 8'h41;
    data_b[7:0] = 8'h41;
    exp_b.push_back(8'h41);
    exp_b.push_back(8'h41);
    write_b = 1'b1;
    finish_msg(1, "ends");
    check("ends_frame_count", st_b.size(), 32'd2);
    if (st_b.size() == 2)
      check("ends_start_spacing", st_b[1] - st_b[0], 32'd71);

    // All-zero buffer, no newline: DONE after acceptance edge plus 32 scan edges
    repeat (2) tick();
    data_b = '0;
    write_b = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 32) check("zero_raw_written_early", {31'd0, written_b}, 32'd0);
      if (e == 33) check("zero_raw_written_on_time", {31'd0, written_b}, 32'd1);
    end
    tick();
    write_b = 1'b0;
    tick();
    @(negedge clk);
    check("zero_raw_busy_clear", {31'd0, busy_b}, 32'd0);
    check("zero_raw_no_frames", exp_b.size(), 32'd0);

    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
